mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_mem_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Byte-serial RAM arbiter between instruction fetch and load/store unit.
// Loads take priority, I/O stores back off while the UART buffer is full, and a flush aborts reads only.
module mem_ctrl #(
    parameter logic [1:0] IO_HI = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_wr,
    input  logic [1:0]  ls_size,
    input  logic        ls_signed,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    input  logic        jp_wrong
);

    typedef enum logic [2:0] {IDLE, IF_RD, LS_RD, LS_WR, DONE} state_t;

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [2:0]  r_len;
    logic        r_is_if;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:8] r_wdata;
    logic [23:0] r_buf;
    logic [31:0] r_mem_a;
    logic [7:0]  r_mem_dout;
    logic        r_mem_wr;
    logic        r_if_done;
    logic        r_ls_done;
    logic [31:0] r_if_data;
    logic [31:0] r_ls_rdata;

    logic        w_io;
    logic        w_ls_ok;
    logic [2:0]  w_next;
    logic [31:0] w_raw;

    function automatic logic [2:0] byte_len(input logic [1:0] size);
        case (size)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] raw, input logic [1:0] size,
                                                input logic sgn);
        case (size)
            2'b00:   return {{24{sgn & raw[7]}}, raw[7:0]};
            2'b01:   return {{16{sgn & raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    assign w_io    = (ls_addr[17:16] == IO_HI);
    assign w_ls_ok = ls_req && !(ls_wr && w_io && io_buffer_full);
    assign w_next  = r_cnt + 3'd1;

    // The last byte of a read is still on mem_din when the transfer completes.
    always_comb begin
        w_raw = {mem_din, r_buf};
        if (r_len == 3'd1)
            w_raw = {24'd0, mem_din};
        else if (r_len == 3'd2)
            w_raw = {16'd0, mem_din, r_buf[7:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= 3'd0;
            r_len      <= 3'd0;
            r_is_if    <= 1'b0;
            r_mem_a    <= 32'd0;
            r_mem_dout <= 8'd0;
            r_mem_wr   <= 1'b0;
            r_if_done  <= 1'b0;
            r_ls_done  <= 1'b0;
            r_if_data  <= 32'd0;
            r_ls_rdata <= 32'd0;
        end else if (rdy) begin
            case (r_state)
                IDLE: begin
                    r_cnt <= 3'd0;
                    if (w_ls_ok) begin
                        r_is_if  <= 1'b0;
                        r_len    <= byte_len(ls_size);
                        r_size   <= ls_size;
                        r_signed <= ls_signed;
                        r_wdata  <= ls_wdata[31:8];
                        r_mem_a  <= ls_addr;
                        if (ls_wr) begin
                            r_state    <= LS_WR;
                            r_mem_wr   <= 1'b1;
                            r_mem_dout <= ls_wdata[7:0];
                        end else begin
                            r_state <= LS_RD;
                        end
                    end else if (if_req) begin
                        r_is_if <= 1'b1;
                        r_len   <= 3'd4;
                        r_mem_a <= if_addr;
                        r_state <= IF_RD;
                    end
                end
                IF_RD, LS_RD: begin
                    if (jp_wrong) begin
                        r_state <= IDLE;
                    end else begin
                        case (r_cnt)
                            3'd1:    r_buf[7:0]   <= mem_din;
                            3'd2:    r_buf[15:8]  <= mem_din;
                            3'd3:    r_buf[23:16] <= mem_din;
                            default: ;
                        endcase
                        r_cnt <= w_next;
                        if (w_next < r_len)
                            r_mem_a <= r_mem_a + 32'd1;
                        if (r_cnt == r_len) begin
                            r_state <= DONE;
                            if (r_is_if) begin
                                r_if_data <= w_raw;
                                r_if_done <= 1'b1;
                            end else begin
                                r_ls_rdata <= load_extend(w_raw, r_size, r_signed);
                                r_ls_done  <= 1'b1;
                            end
                        end
                    end
                end
                LS_WR: begin
                    if (w_next == r_len) begin
                        r_state   <= DONE;
                        r_mem_wr  <= 1'b0;
                        r_ls_done <= 1'b1;
                    end else begin
                        r_cnt   <= w_next;
                        r_mem_a <= r_mem_a + 32'd1;
                        case (w_next)
                            3'd1:    r_mem_dout <= r_wdata[15:8];
                            3'd2:    r_mem_dout <= r_wdata[23:16];
                            default: r_mem_dout <= r_wdata[31:24];
                        endcase
                    end
                end
                DONE: begin
                    r_state   <= IDLE;
                    r_cnt     <= 3'd0;
                    r_if_done <= 1'b0;
                    r_ls_done <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // A stalled cycle must never strobe the RAM or report completion.
    assign mem_wr   = r_mem_wr & rdy;
    assign if_done  = r_if_done & rdy;
    assign ls_done  = r_ls_done & rdy;
    assign mem_a    = r_mem_a;
    assign mem_dout = r_mem_dout;
    assign if_data  = r_if_data;
    assign ls_rdata = r_ls_rdata;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model, transaction-level memory model, directed and random scenarios.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy, io_buffer_full, jp_wrong;
    logic        if_req, ls_req, ls_wr, ls_signed;
    logic [1:0]  ls_size;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a, if_data, ls_rdata;
    logic        mem_wr, if_done, ls_done;

    int checks = 0;
    int failures = 0;

    // RAM: registered read port that shares the global ready, plus a backdoor write port.
    bit [7:0] ram [0:262143];
    bit       written [0:262143];
    logic     tb_we = 1'b0;
    int       tb_wa = 0;
    logic [7:0] tb_wd = 8'd0;
    bit [7:0] model [int];

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_signed(ls_signed),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .jp_wrong(jp_wrong)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] dflt(input int a);
        return 8'((a * 37) + ((a >> 8) * 11) + 5);
    endfunction

    function automatic logic [7:0] ram_rd(input int a);
        return written[a] ? ram[a] : dflt(a);
    endfunction

    always @(posedge clk) begin
        if (rdy) mem_din <= ram_rd(int'(mem_a[17:0]));
        if (mem_wr) begin
            ram[int'(mem_a[17:0])]     <= mem_dout;
            written[int'(mem_a[17:0])] <= 1'b1;
        end
        if (tb_we) begin
            ram[tb_wa]     <= tb_wd;
            written[tb_wa] <= 1'b1;
        end
    end

    function automatic logic [7:0] mget(input int a);
        int m = a & 32'h3FFFF;
        return model.exists(m) ? model[m] : dflt(m);
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [1:0] sz, input bit sgn);
        int n = nbytes(sz);
        logic [31:0] v = 32'd0;
        for (int k = 0; k < n; k++) v = v | (32'(mget(int'(a) + k)) << (8 * k));
        if (sgn && n == 1 && v[7]) v = v | 32'hFFFFFF00;
        if (sgn && n == 2 && v[15]) v = v | 32'hFFFF0000;
        return v;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        for (int k = 0; k < nbytes(sz); k++) model[(int'(a) + k) & 32'h3FFFF] = d[8*k +: 8];
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        if_req = 1'b0; ls_req = 1'b0; ls_wr = 1'b0; ls_signed = 1'b0; ls_size = 2'b10;
        jp_wrong = 1'b0; io_buffer_full = 1'b0; rdy = 1'b1;
    endtask

    task automatic poke(input int a, input logic [7:0] d);
        tb_we = 1'b1; tb_wa = a; tb_wd = d;
        cyc();
        tb_we = 1'b0;
        model[a] = d;
    endtask

    // Drives one request from an idle controller and returns cycles to its done pulse (-1 on timeout).
    task automatic run_txn(input bit is_if, input bit wr, input logic [1:0] sz, input bit sgn,
                           input logic [31:0] addr, input logic [31:0] wdata, input int stall_at,
                           output int lat, output logic [31:0] data);
        lat = -1; data = 32'd0;
        if (is_if) begin if_req = 1'b1; if_addr = addr; end
        else begin
            ls_req = 1'b1; ls_wr = wr; ls_size = sz; ls_signed = sgn; ls_addr = addr; ls_wdata = wdata;
        end
        for (int c = 1; c <= 40; c++) begin
            rdy = (stall_at >= 0 && (c - 1 == stall_at || c - 1 == stall_at + 1)) ? 1'b0 : 1'b1;
            cyc();
            if (is_if ? if_done : ls_done) begin
                lat = c;
                data = is_if ? if_data : ls_rdata;
                break;
            end
        end
        if_req = 1'b0; ls_req = 1'b0; rdy = 1'b1;
        cyc();
    endtask

    task automatic test_reset;
        rst = 1'b1; if_req = 1'b1; ls_req = 1'b1; jp_wrong = 1'(($urandom));
        if_addr = $urandom; ls_addr = $urandom; ls_wdata = $urandom; ls_wr = 1'b1; rdy = 1'b1;
        io_buffer_full = 1'b0; ls_size = 2'b10; ls_signed = 1'b0;
        cyc(); cyc();
        checks++; if (mem_a !== 32'd0) begin failures++; $display("FAIL reset_mem_a got=%h exp=0", mem_a); end
        checks++; if (mem_dout !== 8'd0) begin failures++; $display("FAIL reset_mem_dout got=%h exp=0", mem_dout); end
        checks++; if (mem_wr !== 1'b0) begin failures++; $display("FAIL reset_mem_wr got=%b exp=0", mem_wr); end
        checks++; if (if_done !== 1'b0) begin failures++; $display("FAIL reset_if_done got=%b exp=0", if_done); end
        checks++; if (ls_done !== 1'b0) begin failures++; $display("FAIL reset_ls_done got=%b exp=0", ls_done); end
        checks++; if (if_data !== 32'd0) begin failures++; $display("FAIL reset_if_data got=%h exp=0", if_data); end
        checks++; if (ls_rdata !== 32'd0) begin failures++; $display("FAIL reset_ls_rdata got=%h exp=0", ls_rdata); end
        rst = 1'b0;
        idle_inputs();
        cyc();
    endtask

    task automatic test_fetch;
        int lat = -1;
        poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'hA0); poke(32'h103, 8'h00);
        if_req = 1'b1; if_addr = 32'h100;
        for (int c = 1; c <= 12; c++) begin
            cyc();
            if (c <= 4) begin
                checks++;
                if (mem_a !== 32'h100 + 32'(c - 1)) begin
                    failures++; $display("FAIL fetch_addr cycle=%0d got=%h exp=%h", c, mem_a, 32'h100 + 32'(c - 1));
                end
            end
            if (if_done) begin lat = c; break; end
        end
        checks++; if (lat != 6) begin failures++; $display("FAIL fetch_latency got=%0d exp=6", lat); end
        checks++; if (if_data !== 32'h00A00513) begin failures++; $display("FAIL fetch_data got=%h exp=00a00513", if_data); end
        if_req = 1'b0;
        cyc();
    endtask

    task automatic test_conflict;
        int ls_lat = -1, if_lat = -1;
        logic [31:0] exp_ld;
        for (int k = 0; k < 4; k++) poke(32'h200 + k, 8'($urandom));
        exp_ld = exp_load(32'h200, 2'b10, 1'b0);
        if_req = 1'b1; if_addr = 32'h100;
        ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'b10; ls_signed = 1'b1; ls_addr = 32'h200;
        for (int c = 1; c <= 25; c++) begin
            cyc();
            checks++;
            if (if_done && ls_done) begin failures++; $display("FAIL conflict_both_done cycle=%0d got=11 exp=not both", c); end
            if (ls_done) begin
                ls_lat = c; ls_req = 1'b0;
                checks++; if (ls_rdata !== exp_ld) begin failures++; $display("FAIL conflict_load_data got=%h exp=%h", ls_rdata, exp_ld); end
            end
            if (if_done) begin if_lat = c; break; end
        end
        checks++; if (ls_lat != 6) begin failures++; $display("FAIL conflict_load_latency got=%0d exp=6", ls_lat); end
        checks++; if (if_lat != 13) begin failures++; $display("FAIL conflict_fetch_latency got=%0d exp=13", if_lat); end
        checks++; if (if_data !== 32'h00A00513) begin failures++; $display("FAIL conflict_fetch_data got=%h exp=00a00513", if_data); end
        idle_inputs();
        cyc();
    endtask

    task automatic test_signed_load;
        int lat;
        logic [31:0] d;
        poke(32'h280, 8'h80); poke(32'h281, 8'h90);
        run_txn(1'b0, 1'b0, 2'b00, 1'b1, 32'h280, 32'd0, -1, lat, d);
        checks++; if (d !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_signed got=%h exp=ffffff80", d); end
        checks++; if (lat != 3) begin failures++; $display("FAIL lb_latency got=%0d exp=3", lat); end
        run_txn(1'b0, 1'b0, 2'b00, 1'b0, 32'h280, 32'd0, -1, lat, d);
        checks++; if (d !== 32'h00000080) begin failures++; $display("FAIL lb_unsigned got=%h exp=00000080", d); end
        run_txn(1'b0, 1'b0, 2'b01, 1'b1, 32'h280, 32'd0, -1, lat, d);
        checks++; if (d !== 32'hFFFF9080) begin failures++; $display("FAIL lh_signed got=%h exp=ffff9080", d); end
        checks++; if (lat != 4) begin failures++; $display("FAIL lh_latency got=%0d exp=4", lat); end
    endtask

    task automatic test_half_store;
        int lat;
        logic [31:0] d, exp_hi;
        exp_hi = exp_load(32'h302, 2'b00, 1'b0);
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'b01; ls_addr = 32'h300; ls_wdata = 32'h1234ABCD;
        cyc();
        checks++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h300, 8'hCD}) begin
            failures++; $display("FAIL hstore_byte0 got=%b/%h/%h exp=1/300/cd", mem_wr, mem_a, mem_dout); end
        ls_addr = 32'h777; ls_wdata = 32'h55555555; ls_size = 2'b10;
        cyc();
        checks++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h301, 8'hAB}) begin
            failures++; $display("FAIL hstore_byte1 got=%b/%h/%h exp=1/301/ab", mem_wr, mem_a, mem_dout); end
        cyc();
        checks++; if ({ls_done, mem_wr} !== 2'b10) begin failures++; $display("FAIL hstore_done got=%b%b exp=10", ls_done, mem_wr); end
        ls_req = 1'b0;
        cyc();
        checks++; if (mem_wr !== 1'b0) begin failures++; $display("FAIL hstore_after got=%b exp=0", mem_wr); end
        model_store(32'h300, 2'b01, 32'h1234ABCD);
        run_txn(1'b0, 1'b0, 2'b01, 1'b0, 32'h300, 32'd0, -1, lat, d);
        checks++; if (d !== 32'h0000ABCD) begin failures++; $display("FAIL hstore_readback got=%h exp=0000abcd", d); end
        run_txn(1'b0, 1'b0, 2'b00, 1'b0, 32'h302, 32'd0, -1, lat, d);
        checks++; if (d !== exp_hi) begin failures++; $display("FAIL hstore_untouched got=%h exp=%h", d, exp_hi); end
    endtask

    task automatic test_flush;
        int lat = -1, nwr = 0;
        logic [31:0] d, wd, exp_ld;
        bit spurious = 0;
        if_req = 1'b1; if_addr = 32'h100;
        cyc(); cyc(); cyc();
        jp_wrong = 1'b1; if_req = 1'b0;
        cyc();
        jp_wrong = 1'b0;
        checks++; if (if_done !== 1'b0) begin failures++; $display("FAIL flush_no_done got=%b exp=0", if_done); end
        exp_ld = exp_load(32'h200, 2'b10, 1'b0);
        run_txn(1'b0, 1'b0, 2'b10, 1'b0, 32'h200, 32'd0, -1, lat, d);
        checks++; if (lat != 6) begin failures++; $display("FAIL flush_idle_next latency got=%0d exp=6", lat); end
        checks++; if (d !== exp_ld) begin failures++; $display("FAIL flush_next_load got=%h exp=%h", d, exp_ld); end
        wd = $urandom;
        lat = -1;
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'b10; ls_addr = 32'h340; ls_wdata = wd;
        for (int c = 1; c <= 12; c++) begin
            jp_wrong = (c == 2);
            cyc();
            if (mem_wr) nwr++;
            if (if_done) spurious = 1;
            if (ls_done) begin lat = c; break; end
        end
        jp_wrong = 1'b0; ls_req = 1'b0;
        cyc();
        checks++; if (lat != 5) begin failures++; $display("FAIL flush_store_latency got=%0d exp=5", lat); end
        checks++; if (nwr != 4) begin failures++; $display("FAIL flush_store_writes got=%0d exp=4", nwr); end
        checks++; if (spurious) begin failures++; $display("FAIL flush_store_if_done got=1 exp=0"); end
        model_store(32'h340, 2'b10, wd);
        run_txn(1'b0, 1'b0, 2'b10, 1'b0, 32'h340, 32'd0, -1, lat, d);
        checks++; if (d !== wd) begin failures++; $display("FAIL flush_store_readback got=%h exp=%h", d, wd); end
    endtask

    task automatic test_io_stall;
        int lat = -1, nwr = 0;
        logic [31:0] d, wd;
        bit wr_in_stall = 0;
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'b00; ls_addr = 32'h30000; ls_wdata = 32'h0000005A;
        io_buffer_full = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            cyc();
            checks++; if (mem_wr !== 1'b0) begin failures++; $display("FAIL io_blocked cycle=%0d mem_wr got=%b exp=0", c, mem_wr); end
        end
        io_buffer_full = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            if (ls_done) begin lat = c; break; end
        end
        ls_req = 1'b0;
        cyc();
        checks++; if (lat != 2) begin failures++; $display("FAIL io_store_latency got=%0d exp=2", lat); end
        model_store(32'h30000, 2'b00, 32'h5A);
        run_txn(1'b0, 1'b0, 2'b00, 1'b0, 32'h30000, 32'd0, -1, lat, d);
        checks++; if (d !== 32'h5A) begin failures++; $display("FAIL io_readback got=%h exp=0000005a", d); end
        run_txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 2, lat, d);
        checks++; if (lat != 8) begin failures++; $display("FAIL stall_fetch_latency got=%0d exp=8", lat); end
        checks++; if (d !== 32'h00A00513) begin failures++; $display("FAIL stall_fetch_data got=%h exp=00a00513", d); end
        wd = $urandom; lat = -1;
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'b10; ls_addr = 32'h360; ls_wdata = wd;
        for (int c = 1; c <= 15; c++) begin
            rdy = (c - 1 == 2 || c - 1 == 3) ? 1'b0 : 1'b1;
            cyc();
            if (!rdy && mem_wr) wr_in_stall = 1;
            if (mem_wr) nwr++;
            if (ls_done) begin lat = c; break; end
        end
        ls_req = 1'b0; rdy = 1'b1;
        cyc();
        checks++; if (wr_in_stall) begin failures++; $display("FAIL stall_mem_wr got=1 exp=0"); end
        checks++; if (nwr != 4) begin failures++; $display("FAIL stall_store_writes got=%0d exp=4", nwr); end
        checks++; if (lat != 7) begin failures++; $display("FAIL stall_store_latency got=%0d exp=7", lat); end
        model_store(32'h360, 2'b10, wd);
        run_txn(1'b0, 1'b0, 2'b10, 1'b0, 32'h360, 32'd0, -1, lat, d);
        checks++; if (d !== wd) begin failures++; $display("FAIL stall_store_readback got=%h exp=%h", d, wd); end
    endtask

    task automatic test_reset_mid_store;
        bit seen = 0;
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'b10; ls_addr = 32'h380; ls_wdata = $urandom;
        cyc(); cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0; ls_req = 1'b0;
        checks++; if ({mem_wr, ls_done, mem_a} !== {2'b00, 32'd0}) begin
            failures++; $display("FAIL reset_mid_store got=%b/%b/%h exp=0/0/0", mem_wr, ls_done, mem_a); end
        for (int c = 0; c < 6; c++) begin cyc(); if (ls_done || mem_wr) seen = 1; end
        checks++; if (seen) begin failures++; $display("FAIL reset_mid_store_resume got=1 exp=0"); end
    endtask

    task automatic test_random;
        int lat, exp_lat, stall;
        logic [31:0] d, a, wd, exp_d;
        logic [1:0] sz;
        bit sgn;
        int kind;
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 2);
            a = 32'h400 + $urandom_range(0, 63);
            sz = 2'($urandom);
            sgn = 1'($urandom);
            wd = $urandom;
            stall = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1) : -1;
            if (kind == 0) begin
                a = a & ~32'd3;
                exp_d = exp_load(a, 2'b10, 1'b0);
                exp_lat = 6;
                run_txn(1'b1, 1'b0, 2'b10, 1'b0, a, 32'd0, stall, lat, d);
            end else if (kind == 1) begin
                exp_d = exp_load(a, sz, sgn);
                exp_lat = nbytes(sz) + 2;
                run_txn(1'b0, 1'b0, sz, sgn, a, 32'd0, stall, lat, d);
            end else begin
                exp_d = 32'd0;
                exp_lat = nbytes(sz) + 1;
                run_txn(1'b0, 1'b1, sz, sgn, a, wd, stall, lat, d);
                model_store(a, sz, wd);
            end
            if (stall >= 0) exp_lat += 2;
            checks++;
            if (lat != exp_lat) begin
                failures++; $display("FAIL rand_latency i=%0d kind=%0d got=%0d exp=%0d", i, kind, lat, exp_lat);
            end
            if (kind != 2) begin
                checks++;
                if (d !== exp_d) begin
                    failures++; $display("FAIL rand_data i=%0d kind=%0d addr=%h got=%h exp=%h", i, kind, a, d, exp_d);
                end
            end
        end
    endtask

    initial begin
        if_addr = 32'd0; ls_addr = 32'd0; ls_wdata = 32'd0; rst = 1'b1;
        idle_inputs();
        test_reset();
        test_fetch();
        test_conflict();
        test_signed_load();
        test_half_store();
        test_flush();
        test_io_stall();
        test_reset_mid_store();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
